// File: rtl/tl_ram_responder_if.sv
// TileLink-UL A/D channel bundle between a requesting master and tl_ram_responder.
interface tl_ram_responder_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_size;
    logic [63:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_size;
    logic        d_denied;
    logic [63:0] d_data;

    modport master (
        output a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        input  a_ready, d_valid, d_opcode, d_size, d_denied, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_denied, d_data
    );
endinterface

// File: rtl/tl_ram_responder.sv
// TileLink-UL responder over a single-port 64-bit RAM, one transaction in flight.
// Define TL_RAM_BACK2BACK_EN to accept a new request on the same edge a response is taken.
module tl_ram_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
) (
    input  logic               clk,
    input  logic               rst,
    tl_ram_responder_if.slave  tl
);
    localparam int          IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN    = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam bit          LAT_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_c;
    logic              a_fire, d_fire;

    logic [63:0]       offset;
    logic              in_range, aligned, is_get, is_put, mask_ok, denied;
    logic [IDX_W-1:0]  idx;

    logic [63:0]       mem [DEPTH_WORDS];

    logic [2:0]        d_opcode_q, d_size_q;
    logic              d_denied_q;
    logic [63:0]       d_data_q;

`ifdef TL_RAM_BACK2BACK_EN
    assign ready_c = (state_q == IDLE) || ((state_q == RESP) && tl.d_ready);
`else
    assign ready_c = (state_q == IDLE);
`endif

    // reset gates ready combinationally so nothing is accepted while rst is held
    assign tl.a_ready = ready_c && !rst;
    assign a_fire     = tl.a_valid && tl.a_ready;
    assign tl.d_valid = (state_q == RESP);
    assign d_fire     = tl.d_valid && tl.d_ready;

    assign tl.d_opcode = d_opcode_q;
    assign tl.d_size   = d_size_q;
    assign tl.d_denied = d_denied_q;
    assign tl.d_data   = d_data_q;

    always_comb begin
        offset   = tl.a_address - ADDR_BASE;
        in_range = (tl.a_address >= ADDR_BASE) && (offset < SPAN);
        case (tl.a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = (tl.a_address[0] == 1'b0);
            3'd2:    aligned = (tl.a_address[1:0] == 2'b00);
            3'd3:    aligned = (tl.a_address[2:0] == 3'b000);
            default: aligned = 1'b0;
        endcase
        is_get  = (tl.a_opcode == 3'd4);
        is_put  = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1);
        // PutFullData must cover every byte lane of the word
        mask_ok = !((tl.a_opcode == 3'd0) && (tl.a_mask != 8'hFF));
        denied  = !(in_range && aligned && (is_get || is_put) && mask_ok);
        idx     = offset[IDX_W+2:3];
    end

    always_ff @(posedge clk) begin
        if (a_fire && is_put && !denied) begin
            for (int i = 0; i < 8; i++) begin
                if (tl.a_mask[i]) mem[idx][8*i +: 8] <= tl.a_data[8*i +: 8];
            end
        end
    end

    // response fields are captured once at A-fire and then held until D-fire
    always_ff @(posedge clk) begin
        if (rst) begin
            d_opcode_q <= 3'd0;
            d_size_q   <= 3'd0;
            d_denied_q <= 1'b0;
            d_data_q   <= 64'd0;
        end else if (a_fire) begin
            d_opcode_q <= is_get ? 3'd1 : 3'd0;
            d_size_q   <= tl.a_size;
            d_denied_q <= denied;
            d_data_q   <= (is_get && !denied) ? mem[idx] : 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: ;
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: if (d_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // an accepted request overrides the RESP->IDLE return in back-to-back mode
        if (a_fire) begin
            if (LAT_ONE) begin
                state_d = RESP;
                cnt_d   = 4'd0;
            end else begin
                state_d = WAIT;
                cnt_d   = LAT_M1;
            end
        end
    end
endmodule
